// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command, ALU-issue and result bus bundle for alu_cmd_sequencer
//
// Purpose : groups the three handshake/bus groups of the sequencer.
//   cmd_* : command in  (valid/ready, operands, opcode, tag)
//   alu_* : issue to the registered ALU and its registered result/flags
//   res_* : result out  (valid/ready, data, flags {Arith,Logic,CMP,Shift}, tag, err)
// Modports: slave  = sequencer view, master = environment (producer/ALU/consumer) view.
interface alu_cmd_sequencer_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [15:0]      cmd_a;
    logic [15:0]      cmd_b;
    logic [3:0]       cmd_fun;
    logic [TAG_W-1:0] cmd_tag;

    logic [15:0]      alu_a;
    logic [15:0]      alu_b;
    logic [3:0]       alu_fun;
    logic [15:0]      alu_out;
    logic [3:0]       alu_flags;

    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic [3:0]       res_flags;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_fun, cmd_tag,
        output cmd_ready,
        output alu_a, alu_b, alu_fun,
        input  alu_out, alu_flags,
        output res_valid, res_data, res_flags, res_tag, res_err,
        input  res_ready
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_fun, cmd_tag,
        input  cmd_ready,
        input  alu_a, alu_b, alu_fun,
        output alu_out, alu_flags,
        input  res_valid, res_data, res_flags, res_tag, res_err,
        output res_ready
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and result slot in front of the 16-bit registered ALU
//
// Purpose : buffers commands in a DEPTH-entry FIFO, issues at most one per cycle to the
//           ALU when the result slot frees, and presents each result with its tag.
//           Drives the ALU hold opcode 4'b1111 on every cycle without an issue so the
//           registered ALU output stays stable while the consumer stalls.
// Ports   : i_clk  - clock, all state on rising edge
//           i_rst  - synchronous active-high reset
//           io_bus - alu_cmd_sequencer_if.slave (cmd_*, alu_*, res_* groups)
// Options : ALU_DIV0_CHECK_EN - when defined, a divide (4'b0011) with B = 0 is rejected
//           like the reserved opcode instead of being issued to the ALU.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    alu_cmd_sequencer_if.slave   io_bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [3:0] FUN_HOLD = 4'b1111;
    localparam logic [3:0] FUN_DIV  = 4'b0011;

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_ALU_RES = 2'd1;
    localparam logic [1:0] S_ERR_RES = 2'd2;

    logic [15:0]      r_fifo_a   [DEPTH];
    logic [15:0]      r_fifo_b   [DEPTH];
    logic [3:0]       r_fifo_fun [DEPTH];
    logic [TAG_W-1:0] r_fifo_tag [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_slot;
    logic [TAG_W-1:0] r_res_tag;

    logic [15:0]      w_head_a;
    logic [15:0]      w_head_b;
    logic [3:0]       w_head_fun;
    logic [TAG_W-1:0] w_head_tag;
    logic             w_cmd_ready;
    logic             w_push;
    logic             w_res_valid;
    logic             w_handshake;
    logic             w_slot_free;
    logic             w_dispatch;
    logic             w_head_reject;

    always_comb begin
        w_head_a    = r_fifo_a[r_rd_ptr];
        w_head_b    = r_fifo_b[r_rd_ptr];
        w_head_fun  = r_fifo_fun[r_rd_ptr];
        w_head_tag  = r_fifo_tag[r_rd_ptr];

        w_cmd_ready = (r_count < FULL_CNT);
        w_push      = io_bus.cmd_valid && w_cmd_ready;
        w_res_valid = (r_slot != S_EMPTY);
        w_handshake = w_res_valid && io_bus.res_ready;
        // The slot can take a new command in the same cycle the old result leaves.
        w_slot_free = (r_slot == S_EMPTY) || w_handshake;
        w_dispatch  = (r_count != '0) && w_slot_free;
    end

`ifdef ALU_DIV0_CHECK_EN
    always_comb begin
        w_head_reject = (w_head_fun == FUN_HOLD) ||
                        ((w_head_fun == FUN_DIV) && (w_head_b == 16'd0));
    end
`else
    always_comb begin
        w_head_reject = (w_head_fun == FUN_HOLD);
    end
`endif

    // FIFO storage carries no reset: entries are only read when r_count says they are valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_a[r_wr_ptr]   <= io_bus.cmd_a;
            r_fifo_b[r_wr_ptr]   <= io_bus.cmd_b;
            r_fifo_fun[r_wr_ptr] <= io_bus.cmd_fun;
            r_fifo_tag[r_wr_ptr] <= io_bus.cmd_tag;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_slot    <= S_EMPTY;
            r_res_tag <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_dispatch) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            case ({w_push, w_dispatch})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // The ALU registers its result on the same edge the slot turns ALU_RES,
            // so the slot and the ALU output line up with no extra pipeline stage.
            if (w_dispatch) begin
                r_slot    <= w_head_reject ? S_ERR_RES : S_ALU_RES;
                r_res_tag <= w_head_tag;
            end else if (w_handshake) begin
                r_slot    <= S_EMPTY;
                r_res_tag <= '0;
            end
        end
    end

    always_comb begin
        io_bus.cmd_ready = w_cmd_ready;

        // Anything other than a real issue drives the hold opcode so a stalled
        // result is never overwritten inside the ALU.
        if (w_dispatch && !w_head_reject) begin
            io_bus.alu_a   = w_head_a;
            io_bus.alu_b   = w_head_b;
            io_bus.alu_fun = w_head_fun;
        end else begin
            io_bus.alu_a   = 16'd0;
            io_bus.alu_b   = 16'd0;
            io_bus.alu_fun = FUN_HOLD;
        end

        io_bus.res_valid = w_res_valid;
        io_bus.res_data  = 16'd0;
        io_bus.res_flags = 4'd0;
        io_bus.res_err   = 1'b0;
        io_bus.res_tag   = '0;
        case (r_slot)
            S_ALU_RES: begin
                io_bus.res_data  = io_bus.alu_out;
                io_bus.res_flags = io_bus.alu_flags;
                io_bus.res_tag   = r_res_tag;
            end
            S_ERR_RES: begin
                io_bus.res_err   = 1'b1;
                io_bus.res_tag   = r_res_tag;
            end
            default: begin
                io_bus.res_data  = 16'd0;
            end
        endcase
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic saw_div0 = 1'b0;
    int   accepts;

    alu_cmd_sequencer_if #(.TAG_W(TAG_W)) bus ();

    alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    always #5 clk = ~clk;

    // Reference registered ALU: 1111 holds the previous output.
    initial begin
        bus.alu_out   = 16'd0;
        bus.alu_flags = 4'd0;
    end

    always @(posedge clk) begin
        case (bus.alu_fun)
            4'b0000: begin bus.alu_out <= bus.alu_a + bus.alu_b; bus.alu_flags <= 4'b1000; end
            4'b0011: begin
                bus.alu_out   <= (bus.alu_b == 16'd0) ? 16'hFFFF : bus.alu_a / bus.alu_b;
                bus.alu_flags <= 4'b1000;
                if (bus.alu_b == 16'd0) saw_div0 <= 1'b1;
            end
            4'b0100: begin bus.alu_out <= bus.alu_a & bus.alu_b; bus.alu_flags <= 4'b0100; end
            4'b1011: begin
                bus.alu_out   <= (bus.alu_a > bus.alu_b) ? 16'd2 : ((bus.alu_a == bus.alu_b) ? 16'd1 : 16'd0);
                bus.alu_flags <= 4'b0010;
            end
            4'b1111: begin end
            default: begin bus.alu_out <= 16'd0; bus.alu_flags <= 4'b0000; end
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] fun, input logic [TAG_W-1:0] tag);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_fun   = fun;
        bus.cmd_tag   = tag;
    endtask

    task automatic clr_cmd();
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = 16'd0;
        bus.cmd_b     = 16'd0;
        bus.cmd_fun   = 4'd0;
        bus.cmd_tag   = '0;
    endtask

    initial begin
        clr_cmd();
        bus.res_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_val("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_val("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_val("rst_alu_fun",   32'(bus.alu_fun),   32'hF);
        check_val("rst_alu_a",     32'(bus.alu_a),     32'd0);
        check_val("rst_alu_b",     32'(bus.alu_b),     32'd0);

        // Add 3 + 4, tag 5
        set_cmd(16'h0003, 16'h0004, 4'b0000, 4'd5);
        tick();
        clr_cmd();
        check_val("add_issue_fun", 32'(bus.alu_fun), 32'h0);
        check_val("add_issue_a",   32'(bus.alu_a),   32'h3);
        check_val("add_not_yet",   32'(bus.res_valid), 32'd0);
        tick();
        check_val("add_valid", 32'(bus.res_valid), 32'd1);
        check_val("add_data",  32'(bus.res_data),  32'h0007);
        check_val("add_flags", 32'(bus.res_flags), 32'b1000);
        check_val("add_tag",   32'(bus.res_tag),   32'd5);
        check_val("add_err",   32'(bus.res_err),   32'd0);
        tick();
        check_val("add_drained", 32'(bus.res_valid), 32'd0);

        // Backpressure
        bus.res_ready = 1'b0;
        set_cmd(16'h00F0, 16'h0FF0, 4'b0100, 4'd1);
        tick();
        clr_cmd();
        check_val("bp_issue_fun", 32'(bus.alu_fun), 32'h4);
        set_cmd(16'h0001, 16'h0002, 4'b0000, 4'd2);
        tick();
        clr_cmd();
        for (int i = 0; i < 5; i++) begin
            check_val("bp_stall_valid", 32'(bus.res_valid), 32'd1);
            check_val("bp_stall_fun",   32'(bus.alu_fun),   32'hF);
            check_val("bp_stall_data",  32'(bus.res_data),  32'h00F0);
            check_val("bp_stall_flags", 32'(bus.res_flags), 32'b0100);
            check_val("bp_stall_tag",   32'(bus.res_tag),   32'd1);
            tick();
        end
        bus.res_ready = 1'b1;
        #1;
        check_val("bp_release_fun", 32'(bus.alu_fun), 32'h0);
        tick();
        check_val("bp_second_valid", 32'(bus.res_valid), 32'd1);
        check_val("bp_second_data",  32'(bus.res_data),  32'h0003);
        check_val("bp_second_tag",   32'(bus.res_tag),   32'd2);
        tick();
        check_val("bp_drained", 32'(bus.res_valid), 32'd0);

        // Reject followed by compare
        set_cmd(16'h0001, 16'h0002, 4'b1111, 4'd3);
        tick();
        set_cmd(16'h0005, 16'h0002, 4'b1011, 4'd4);
        #1;
        check_val("rej_no_issue", 32'(bus.alu_fun), 32'hF);
        tick();
        clr_cmd();
        check_val("rej_valid", 32'(bus.res_valid), 32'd1);
        check_val("rej_err",   32'(bus.res_err),   32'd1);
        check_val("rej_data",  32'(bus.res_data),  32'd0);
        check_val("rej_flags", 32'(bus.res_flags), 32'd0);
        check_val("rej_tag",   32'(bus.res_tag),   32'd3);
        check_val("cmp_issue_fun", 32'(bus.alu_fun), 32'hB);
        tick();
        check_val("cmp_data",  32'(bus.res_data),  32'h0002);
        check_val("cmp_flags", 32'(bus.res_flags), 32'b0010);
        check_val("cmp_tag",   32'(bus.res_tag),   32'd4);
        check_val("cmp_err",   32'(bus.res_err),   32'd0);
        tick();
        check_val("cmp_drained", 32'(bus.res_valid), 32'd0);

        // Divide by zero, then a normal divide
        set_cmd(16'h0010, 16'h0000, 4'b0011, 4'd6);
        tick();
        clr_cmd();
`ifdef ALU_DIV0_CHECK_EN
        check_val("div0_issue_fun", 32'(bus.alu_fun), 32'hF);
`else
        check_val("div0_issue_fun", 32'(bus.alu_fun), 32'h3);
`endif
        tick();
        check_val("div0_valid", 32'(bus.res_valid), 32'd1);
        check_val("div0_tag",   32'(bus.res_tag),   32'd6);
`ifdef ALU_DIV0_CHECK_EN
        check_val("div0_err",  32'(bus.res_err),  32'd1);
        check_val("div0_data", 32'(bus.res_data), 32'd0);
`else
        check_val("div0_err",  32'(bus.res_err),  32'd0);
`endif
        tick();
        set_cmd(16'h0010, 16'h0004, 4'b0011, 4'd7);
        tick();
        clr_cmd();
        check_val("div_issue_fun", 32'(bus.alu_fun), 32'h3);
        tick();
        check_val("div_data", 32'(bus.res_data), 32'h0004);
        check_val("div_err",  32'(bus.res_err),  32'd0);
        check_val("div_tag",  32'(bus.res_tag),  32'd7);
        tick();
`ifdef ALU_DIV0_CHECK_EN
        check_val("div0_alu_saw", 32'(saw_div0), 32'd0);
`else
        check_val("div0_alu_saw", 32'(saw_div0), 32'd1);
`endif

        // Full FIFO: DEPTH in FIFO plus one in the slot
        bus.res_ready = 1'b0;
        accepts = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            set_cmd(16'(i * 16 + 1), 16'(i), 4'b0000, TAG_W'(i + 8));
            if (bus.cmd_ready) accepts++;
            tick();
        end
        clr_cmd();
        check_val("full_accepts",   32'(accepts),         32'(DEPTH + 1));
        check_val("full_cmd_ready", 32'(bus.cmd_ready),   32'd0);
        bus.res_ready = 1'b1;
        for (int k = 0; k < DEPTH + 1; k++) begin
            check_val("drain_valid", 32'(bus.res_valid), 32'd1);
            check_val("drain_tag",   32'(bus.res_tag),   32'(k + 8));
            check_val("drain_data",  32'(bus.res_data),  32'(k * 17 + 1));
            tick();
        end
        check_val("drain_done", 32'(bus.res_valid), 32'd0);
        check_val("drain_ready", 32'(bus.cmd_ready), 32'd1);

        // Reset mid-run with commands buffered
        bus.res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_cmd(16'(i + 1), 16'(i + 1), 4'b0000, TAG_W'(i + 1));
            tick();
        end
        clr_cmd();
        check_val("pre_rst_valid", 32'(bus.res_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_rst_valid",     32'(bus.res_valid), 32'd0);
        check_val("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_val("mid_rst_alu_fun",   32'(bus.alu_fun),   32'hF);
        check_val("mid_rst_tag",       32'(bus.res_tag),   32'd0);
        check_val("mid_rst_data",      32'(bus.res_data),  32'd0);
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("post_rst_no_stale", 32'(bus.res_valid), 32'd0);
            check_val("post_rst_alu_fun",  32'(bus.alu_fun),   32'hF);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front-end for the 16-bit registered ALU. It accepts operation commands over a valid/ready interface, buffers them in a small FIFO, issues at most one per cycle to the ALU, and returns each registered ALU result, flags and tag over a second valid/ready interface. While the result consumer stalls, it drives the ALU's hold opcode (4'b1111) so the ALU keeps its output stable.

## Interface
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- TAG_W, 4, width of the caller's command tag
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- CMD_VALID  in  1  command present
- CMD_READY  out  1  FIFO can accept (count < DEPTH)
- CMD_A, CMD_B  in  16  operands
- CMD_FUN  in  4  ALU opcode
- CMD_TAG  in  TAG_W  caller tag, returned with result
- ALU_A, ALU_B  out  16  operands to ALU
- ALU_FUN  out  4  opcode to ALU
- ALU_OUT  in  16  registered ALU result
- ALU_FLAGS  in  4  {Arith, Logic, CMP, Shift} registered ALU flags
- RES_VALID  out  1  result slot occupied
- RES_READY  in  1  consumer takes result
- RES_DATA  out  16  result
- RES_FLAGS  out  4  flags, same order as ALU_FLAGS
- RES_TAG  out  TAG_W  tag of the command
- RES_ERR  out  1  command rejected, not executed

## Operation
- Push: CMD_VALID && CMD_READY at an edge writes {A,B,FUN,TAG} at the tail. No bypass; an empty FIFO still takes one cycle before the command can issue.
- Result slot state: EMPTY, ALU_RES, ERR_RES.
- Slot frees this cycle: slot EMPTY, or RES_VALID && RES_READY.
- Dispatch: when the FIFO is non-empty and the slot frees, the head pops and is classified as follows.
  - Normal: ALU_A/ALU_B/ALU_FUN = head fields combinationally for that cycle; slot → ALU_RES; tag captured.
  - Reject (CMD_FUN = 4'b1111 reserved; plus the divide-by-zero case under Configuration): ALU not issued; slot → ERR_RES; tag captured.
- No dispatch: ALU_FUN = 4'b1111, ALU_A = ALU_B = 0. The slot goes EMPTY on handshake, otherwise it holds.
- Result outputs:
  - ALU_RES: RES_DATA = ALU_OUT, RES_FLAGS = ALU_FLAGS, RES_ERR = 0.
  - ERR_RES: RES_DATA = 0, RES_FLAGS = 0, RES_ERR = 1.
  - EMPTY: RES_DATA, RES_FLAGS, RES_ERR and RES_TAG all 0.
- The ALU output stays valid while stalled only because 1111 is driven every non-dispatch cycle.
- Ordering: results are returned strictly in command order. At most one command is outstanding past the FIFO.
- Simultaneous push and pop updates count by 0. A push when full is impossible because CMD_READY = 0. A pop makes room only from the next cycle.

## Timing
- Reset values (edge with RST = 1): FIFO empty (count 0, pointers 0); slot EMPTY; RES_VALID = 0; CMD_READY = 1 in the following cycle; ALU_FUN = 4'b1111, ALU_A = ALU_B = 0.
- Latency: command accepted at edge e0 → dispatched during cycle e0–e1 → ALU registers at e1 → RES_VALID = 1 after e1. Minimum is 2 edges.
- Throughput: 1 result/cycle with RES_READY held high and the FIFO non-empty.
- Reject latency equals normal latency.
- RST mid-operation drops buffered and outstanding commands without a result. ALU_OUT after reset is ignored because the slot is EMPTY.
- Pointers wrap modulo DEPTH; count is a separate log2(DEPTH)+1-bit register.

## Configuration
- ALU_DIV0_CHECK_EN defined: a head command with CMD_FUN = 4'b0011 and CMD_B = 0 is a reject (RES_ERR = 1, RES_DATA = 0) and is never issued to the ALU.
- Not defined: it is issued normally and RES_DATA is whatever the ALU produces; RES_ERR is asserted only for FUN = 1111.

## Test plan
- Add, RES_READY = 1: A = 0x0003, B = 0x0004, FUN = 0000, TAG = 5 → 2 edges later RES_DATA = 0x0007, RES_FLAGS = 1000, RES_TAG = 5, RES_ERR = 0.
- Backpressure: issue 0x00F0 AND 0x0FF0 (FUN 0100), hold RES_READY = 0 for 5 cycles while issuing a second command. Required response:
  - ALU_FUN = 1111 throughout the stall.
  - RES_DATA stays 0x00F0, flags 0100.
  - On release, the second result follows on the next cycle.
- Full FIFO: RES_READY = 0, push DEPTH + 2 commands back-to-back → CMD_READY drops after DEPTH + 1 accepts (DEPTH in FIFO + 1 in slot). Draining returns all of them in order with correct tags.
- Reject: FUN = 1111, TAG = 3 → RES_ERR = 1, RES_DATA = 0, RES_TAG = 3, ALU_FUN stays 1111. A following compare 0x0005 > 0x0002 (FUN 1011) → RES_DATA = 0x0002, flags 0010.
- Divide-by-zero: 0x0010 / 0x0000 (FUN 0011) with ALU_DIV0_CHECK_EN defined → RES_ERR = 1, ALU never sees FUN 0011. Not defined → RES_ERR = 0. 0x0010 / 0x0004 → 0x0004 in both builds.
- Reset mid-run: 3 commands buffered, RST = 1 for one edge → RES_VALID = 0, CMD_READY = 1, ALU_FUN = 1111, no stale results emitted afterwards.
